// File: rtl/plot_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// plot_arbiter_if : requester/plotter signal bundle for plot_arbiter
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
interface plot_arbiter_if;
  logic       req0;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [1:0] sel0;
  logic       req1;
  logic [7:0] x1;
  logic [6:0] y1;
  logic [1:0] sel1;
  logic       ack0;
  logic       ack1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [1:0] sel_out;
  logic       enable;
  logic       busy;

  modport master (
    output req0, x0, y0, sel0, req1, x1, y1, sel1,
    input  ack0, ack1, gnt0, gnt1, x_out, y_out, sel_out, enable, busy
  );

  modport slave (
    input  req0, x0, y0, sel0, req1, x1, y1, sel1,
    output ack0, ack1, gnt0, gnt1, x_out, y_out, sel_out, enable, busy
  );
endinterface
`default_nettype wire

// File: rtl/plot_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// plot_arbiter : round-robin arbiter sharing the cell plotter between two ports
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module plot_arbiter #(
  parameter int DRAW_CYCLES = 16
) (
  input  wire logic     clock,
  input  wire logic     resetn,
  plot_arbiter_if.slave bus
);

  localparam int              CW     = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
  localparam logic [CW-1:0]   c_TERM = CW'(DRAW_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_en;
  logic          r_busy;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic [1:0]    r_sel;

  logic w_any;
  logic w_pick1;

  // r_last = 1 means port 1 was served last, so port 0 wins the next tie
  assign w_any   = bus.req0 | bus.req1;
  assign w_pick1 = bus.req1 & (~bus.req0 | ~r_last);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_sel   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_DRAW;
            r_cnt   <= '0;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_x     <= w_pick1 ? bus.x1   : bus.x0;
            r_y     <= w_pick1 ? bus.y1   : bus.y0;
            r_sel   <= w_pick1 ? bus.sel1 : bus.sel0;
          end
        end
        S_DRAW: begin
          if (r_cnt == c_TERM) begin
            r_state <= S_DONE;
            r_en    <= 1'b0;
            r_ack0  <= r_gnt0;
            r_ack1  <= r_gnt1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= r_gnt1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0    = r_ack0;
  assign bus.ack1    = r_ack1;
  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.x_out   = r_x;
  assign bus.y_out   = r_y;
  assign bus.sel_out = r_sel;
  assign bus.enable  = r_en;
  assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_plot_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_plot_arbiter : checks plot_arbiter (DRAW_CYCLES 16 and 1) against a model
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_plot_arbiter;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  plot_arbiter_if bus16 ();
  plot_arbiter_if bus1 ();

  plot_arbiter #(.DRAW_CYCLES(16)) dut16 (.clock(clock), .resetn(resetn), .bus(bus16));
  plot_arbiter #(.DRAW_CYCLES(1))  dut1  (.clock(clock), .resetn(resetn), .bus(bus1));

  // index [d][p]: d = 0 for the 16-cycle DUT, 1 for the 1-cycle DUT; p = port
  logic       s_req [2][2];
  logic [7:0] s_x   [2][2];
  logic [6:0] s_y   [2][2];
  logic [1:0] s_sel [2][2];
  logic       a_ack [2][2];
  logic       a_gnt [2][2];
  logic [7:0] a_x   [2];
  logic [6:0] a_y   [2];
  logic [1:0] a_sel [2];
  logic       a_en  [2];
  logic       a_busy[2];

  assign bus16.req0 = s_req[0][0]; assign bus16.x0 = s_x[0][0]; assign bus16.y0 = s_y[0][0]; assign bus16.sel0 = s_sel[0][0];
  assign bus16.req1 = s_req[0][1]; assign bus16.x1 = s_x[0][1]; assign bus16.y1 = s_y[0][1]; assign bus16.sel1 = s_sel[0][1];
  assign bus1.req0  = s_req[1][0]; assign bus1.x0  = s_x[1][0]; assign bus1.y0  = s_y[1][0]; assign bus1.sel0  = s_sel[1][0];
  assign bus1.req1  = s_req[1][1]; assign bus1.x1  = s_x[1][1]; assign bus1.y1  = s_y[1][1]; assign bus1.sel1  = s_sel[1][1];

  assign a_ack[0][0] = bus16.ack0; assign a_ack[0][1] = bus16.ack1;
  assign a_gnt[0][0] = bus16.gnt0; assign a_gnt[0][1] = bus16.gnt1;
  assign a_ack[1][0] = bus1.ack0;  assign a_ack[1][1] = bus1.ack1;
  assign a_gnt[1][0] = bus1.gnt0;  assign a_gnt[1][1] = bus1.gnt1;
  assign a_x[0] = bus16.x_out; assign a_y[0] = bus16.y_out; assign a_sel[0] = bus16.sel_out;
  assign a_x[1] = bus1.x_out;  assign a_y[1] = bus1.y_out;  assign a_sel[1] = bus1.sel_out;
  assign a_en[0] = bus16.enable; assign a_busy[0] = bus16.busy;
  assign a_en[1] = bus1.enable;  assign a_busy[1] = bus1.busy;

  int n_pass;
  int n_total;
  bit cmp_on;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int dc(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  // Model: m_k = cycles since the grant edge (0 = idle); draw is k=1..D, ack at k=D+1
  int         m_k   [2];
  int         m_port[2];
  int         m_last[2];
  logic [7:0] m_x   [2];
  logic [6:0] m_y   [2];
  logic [1:0] m_sel [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_k[d] = 0; m_port[d] = 0; m_last[d] = 1;
      m_x[d] = '0; m_y[d] = '0; m_sel[d] = '0;
    end
  endtask

  task automatic model_step(input int d);
    int p;
    if (m_k[d] == 0) begin
      if (s_req[d][0] || s_req[d][1]) begin
        if (s_req[d][0] && s_req[d][1]) p = 1 - m_last[d];
        else p = s_req[d][0] ? 0 : 1;
        m_port[d] = p;
        m_x[d] = s_x[d][p]; m_y[d] = s_y[d][p]; m_sel[d] = s_sel[d][p];
        m_k[d] = 1;
      end
    end else if (m_k[d] == dc(d) + 1) begin
      m_last[d] = m_port[d];
      m_k[d] = 0;
    end else begin
      m_k[d]++;
    end
  endtask

  always @(negedge resetn) model_reset();
  always @(posedge clock) if (resetn) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp_cycle(input int d);
    int k;
    bit e_busy, e_en;
    k = m_k[d];
    e_busy = (k != 0);
    e_en   = (k >= 1) && (k <= dc(d));
    chk($sformatf("d%0d_busy", d), a_busy[d], e_busy);
    chk($sformatf("d%0d_enable", d), a_en[d], e_en);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("d%0d_gnt%0d", d, p), a_gnt[d][p], e_busy && (m_port[d] == p));
      chk($sformatf("d%0d_ack%0d", d, p), a_ack[d][p], (k == dc(d) + 1) && (m_port[d] == p));
    end
    chk($sformatf("d%0d_x_out", d), a_x[d], m_x[d]);
    chk($sformatf("d%0d_y_out", d), a_y[d], m_y[d]);
    chk($sformatf("d%0d_sel_out", d), a_sel[d], m_sel[d]);
    chk($sformatf("d%0d_excl", d),
        (a_ack[d][0] & a_ack[d][1]) | (a_gnt[d][0] & a_gnt[d][1]) |
        (a_en[d] & ~(a_gnt[d][0] ^ a_gnt[d][1])), 0);
  endtask

  always @(negedge clock) if (cmp_on) begin
    cmp_cycle(0);
    cmp_cycle(1);
  end

  int gq[$];
  int gaps[$];

  task automatic wait_idle(input int d, input string name);
    int n;
    n = 0;
    while (a_busy[d] && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(name, a_busy[d], 0);
  endtask

  task automatic pulse_reset();
    @(negedge clock); #2 resetn = 1'b0;
    @(negedge clock); #2 resetn = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int bad, en_n, low_run, n;
    bit prev_g0, prev_g1, seen;
    bit pend[2];
    n_pass = 0; n_total = 0; cmp_on = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        s_req[d][p] = 1'b0; s_x[d][p] = '0; s_y[d][p] = '0; s_sel[d][p] = '0;
      end
    model_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    cmp_on = 1'b1;
    chk("reset_outputs", {a_busy[0], a_en[0], a_gnt[0][0], a_gnt[0][1], a_ack[0][0], a_ack[0][1]}, 0);
    chk("reset_xy", {a_x[0], a_y[0], a_sel[0]}, 0);
    #2 resetn = 1'b1;

    bad = 0;
    repeat (50) begin
      @(negedge clock);
      bad |= a_busy[0] | a_en[0] | a_busy[1] | a_en[1];
    end
    chk("idle_50", bad, 0);

    // single port-0 request
    s_req[0][0] = 1'b1; s_x[0][0] = 8'd20; s_y[0][0] = 7'd35; s_sel[0][0] = 2'b01;
    en_n = 0; bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk("single_x", a_x[0], 20);
        chk("single_y", a_y[0], 35);
        chk("single_sel", a_sel[0], 1);
        chk("single_gnt0", a_gnt[0][0], 1);
        chk("model_pin_x", m_x[0], 20);
      end
      en_n += a_en[0];
      bad |= a_ack[0][0] | a_ack[0][1];
    end
    chk("single_en_cycles", en_n, 16);
    @(negedge clock);
    chk("single_ack0", a_ack[0][0], 1);
    chk("single_en_off", a_en[0], 0);
    bad |= a_ack[0][1];
    s_req[0][0] = 1'b0;
    @(negedge clock);
    chk("single_idle", a_busy[0] | a_ack[0][0], 0);
    chk("single_no_early_ack", bad, 0);

    // continuous ties alternate, starting with port 0 after reset
    pulse_reset();
    s_req[0][0] = 1'b1; s_x[0][0] = 8'd1; s_y[0][0] = 7'd2; s_sel[0][0] = 2'd2;
    s_req[0][1] = 1'b1; s_x[0][1] = 8'd3; s_y[0][1] = 7'd4; s_sel[0][1] = 2'd3;
    pend[0] = 0; pend[1] = 0; prev_g0 = 0; prev_g1 = 0; seen = 0; low_run = 0; n = 0;
    while (gq.size() < 5 && n < 200) begin
      @(negedge clock);
      n++;
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin s_req[0][p] = 1'b1; pend[p] = 0; end
        if (a_ack[0][p]) begin s_req[0][p] = 1'b0; pend[p] = 1; end
      end
      if (a_gnt[0][0] && !prev_g0) gq.push_back(0);
      if (a_gnt[0][1] && !prev_g1) gq.push_back(1);
      prev_g0 = a_gnt[0][0]; prev_g1 = a_gnt[0][1];
      if (a_en[0]) begin
        if (seen && low_run > 0) gaps.push_back(low_run);
        low_run = 0; seen = 1;
      end else if (seen) low_run++;
    end
    chk("rr_grant_count", (gq.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant_%0d", i), (gq.size() > i) ? gq[i] : -1, i % 2);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rr_gap_%0d", i), (gaps.size() > i) ? gaps[i] : -1, 2);
    s_req[0][0] = 1'b0; s_req[0][1] = 1'b0;
    wait_idle(0, "rr_drain");
    @(negedge clock);

    // x1 changes during the draw must not reach x_out
    s_req[0][1] = 1'b1; s_x[0][1] = 8'd40; s_y[0][1] = 7'd10; s_sel[0][1] = 2'd2;
    repeat (5) @(negedge clock);
    s_x[0][1] = 8'd100;
    repeat (11) @(negedge clock);
    chk("hold_x_T16", a_x[0], 40);
    chk("hold_en_T16", a_en[0], 1);
    @(negedge clock);
    chk("hold_ack1", a_ack[0][1], 1);
    s_req[0][1] = 1'b0;
    @(negedge clock);
    s_req[0][1] = 1'b1;
    @(negedge clock);
    chk("next_grant_x", a_x[0], 100);

    // reset in the middle of a port-1 draw
    repeat (7) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("midreset_en", a_en[0], 0);
    chk("midreset_gnt1", a_gnt[0][1], 0);
    chk("midreset_x", a_x[0], 0);
    s_req[0][1] = 1'b0;
    @(negedge clock); #2 resetn = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      bad |= a_ack[0][1];
    end
    chk("midreset_no_ack1", bad, 0);
    s_req[0][0] = 1'b1; s_req[0][1] = 1'b1;
    @(negedge clock);
    chk("midreset_tie_gnt0", a_gnt[0][0], 1);
    chk("midreset_tie_gnt1", a_gnt[0][1], 0);
    s_req[0][0] = 1'b0; s_req[0][1] = 1'b0;
    wait_idle(0, "midreset_drain");

    // DRAW_CYCLES = 1
    @(negedge clock);
    s_req[1][1] = 1'b1; s_x[1][1] = 8'd7; s_y[1][1] = 7'd3; s_sel[1][1] = 2'd3;
    @(negedge clock);
    chk("d1_en_T1", a_en[1], 1);
    chk("d1_gnt1_T1", a_gnt[1][1], 1);
    chk("d1_x_T1", a_x[1], 7);
    @(negedge clock);
    chk("d1_en_T2", a_en[1], 0);
    chk("d1_ack1_T2", a_ack[1][1], 1);
    s_req[1][1] = 1'b0;
    @(negedge clock);
    chk("d1_idle_T3", a_busy[1], 0);

    // randomized traffic on both DUTs
    repeat (4000) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          if (s_req[d][p] && a_ack[d][p]) s_req[d][p] = 1'b0;
          else if (!s_req[d][p] && !a_gnt[d][p] && ($urandom % 3 == 0)) begin
            s_req[d][p] = 1'b1;
            s_x[d][p]   = 8'($urandom);
            s_y[d][p]   = 7'($urandom);
            s_sel[d][p] = 2'($urandom);
          end else if (a_gnt[d][p] && ($urandom % 8 == 0)) begin
            s_x[d][p]   = 8'($urandom);
            s_y[d][p]   = 7'($urandom);
            s_sel[d][p] = 2'($urandom);
          end else if (s_req[d][p] && a_gnt[d][p] && ($urandom % 20 == 0)) begin
            s_req[d][p] = 1'b0;
          end
        end
    end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) s_req[d][p] = 1'b0;
    wait_idle(0, "final_drain0");
    wait_idle(1, "final_drain1");
    repeat (3) @(negedge clock);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
